// File: rtl/mm2s_reader.sv
// mm2s_reader: memory-to-stream frame reader.
//   Each frame fetches img_width*img_height pixels starting at mm2s_addr with AXI4
//   INCR read bursts. Beats are buffered in a 2*BURST_LEN FIFO and unpacked
//   LSB-first into one-pixel AXI4-Stream beats (tuser = start of frame,
//   tlast = end of line). Frames free-run back to back.
// Ports:
//   aclk_i, reset_i          clock, synchronous active-high reset
//   img_width_i/height_i     frame geometry, sampled in the mm2s_sof cycle
//   mm2s_addr_i, mm2s_sof_o  frame base address and frame-start pulse
//   m_axis_*                 pixel stream out
//   m_axi_ar*, m_axi_r*      AXI4 read address / read data channels
// Optional feature: define MM2S_RESP_CHK_EN to add mm2s_rresp_err_o, a sticky
//   flag set by any accepted beat with an SLVERR/DECERR response.
//
// state   | meaning
// S_IDLE  | between frames, moves straight on to S_START
// S_START | mm2s_sof pulse, latch base address, width and word count
// S_REQ   | wait for FIFO space, then hold AR until arready
// S_DATA  | accept read beats into the FIFO until rlast
// S_DRAIN | all words requested, wait for the FIFO to empty
module mm2s_reader #(
  parameter int C_PIXEL_WIDTH      = 8,
  parameter int C_IMG_WBITS        = 12,
  parameter int C_IMG_HBITS        = 12,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          aclk_i,
  input  logic                          reset_i,
  input  logic [C_IMG_WBITS-1:0]        img_width_i,
  input  logic [C_IMG_HBITS-1:0]        img_height_i,
  output logic                          mm2s_sof_o,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] mm2s_addr_i,
  output logic                          m_axis_tvalid_o,
  input  logic                          m_axis_tready_i,
  output logic [C_PIXEL_WIDTH-1:0]      m_axis_tdata_o,
  output logic                          m_axis_tuser_o,
  output logic                          m_axis_tlast_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [7:0]                    m_axi_arlen_o,
  output logic [2:0]                    m_axi_arsize_o,
  output logic [1:0]                    m_axi_arburst_o,
  output logic                          m_axi_arlock_o,
  output logic [3:0]                    m_axi_arcache_o,
  output logic [2:0]                    m_axi_arprot_o,
  output logic [3:0]                    m_axi_arqos_o,
  output logic                          m_axi_arvalid_o,
  input  logic                          m_axi_arready_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]                    m_axi_rresp_i,
  input  logic                          m_axi_rlast_i,
  input  logic                          m_axi_rvalid_i,
  output logic                          m_axi_rready_o
`ifdef MM2S_RESP_CHK_EN
  ,output logic                         mm2s_rresp_err_o
`endif
);

  localparam int PPB     = C_M_AXI_DATA_WIDTH / C_PIXEL_WIDTH;
  localparam int BYTES   = C_M_AXI_DATA_WIDTH / 8;
  localparam int BL      = C_M_AXI_BURST_LEN;
  localparam int DEPTH   = 2 * BL;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WORDS_W = C_IMG_WBITS + C_IMG_HBITS;
  localparam int PIX_W   = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int AW      = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_START, S_REQ, S_DATA, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [C_IMG_WBITS-1:0]  width_q, width_d;
  logic [WORDS_W-1:0]      words_left_q, words_left_d;
  logic                    arvalid_q, arvalid_d;
  logic [7:0]              arlen_q, arlen_d;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PIX_W-1:0]        pix_idx_q, pix_idx_d;
  logic [C_IMG_WBITS-1:0]  col_q, col_d;
  logic                    first_q, first_d;

  logic [CNT_W-1:0]        fifo_free;
  logic [WORDS_W-1:0]      next_len, burst_words;
  logic [AW-1:0]           burst_bytes;
  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_head;
  logic push, pop, accept, beat_done, tvalid, tlast;

  assign fifo_free   = CNT_W'(DEPTH) - cnt_q;
  assign next_len    = (words_left_q > WORDS_W'(BL)) ? WORDS_W'(BL) : words_left_q;
  assign burst_words = WORDS_W'(arlen_q) + WORDS_W'(1);
  assign burst_bytes = (AW'(arlen_q) + AW'(1)) << $clog2(BYTES);

  // rready is only raised in S_DATA, and S_REQ only issues AR once a full
  // burst fits, so a push never meets a full FIFO.
  assign m_axi_rready_o = (state_q == S_DATA);
  assign push      = m_axi_rvalid_i & m_axi_rready_o;
  assign tvalid    = (cnt_q != '0);
  assign accept    = tvalid & m_axis_tready_i;
  assign beat_done = (pix_idx_q == PIX_W'(PPB - 1));
  assign pop       = accept & beat_done;
  assign tlast     = tvalid & (col_q == (width_q - C_IMG_WBITS'(1)));
  assign fifo_head = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    width_d      = width_q;
    words_left_d = words_left_q;
    arvalid_d    = arvalid_q;
    arlen_d      = arlen_q;
    unique case (state_q)
      S_IDLE:  state_d = S_START;
      S_START: begin
        addr_d       = mm2s_addr_i;
        width_d      = img_width_i;
        words_left_d = (WORDS_W'(img_width_i) / WORDS_W'(PPB)) * WORDS_W'(img_height_i);
        state_d      = S_REQ;
      end
      S_REQ: begin
        if (arvalid_q) begin
          if (m_axi_arready_i) begin
            arvalid_d    = 1'b0;
            addr_d       = addr_q + burst_bytes;
            words_left_d = words_left_q - burst_words;
            state_d      = S_DATA;
          end
        end else if (fifo_free >= CNT_W'(BL)) begin
          arvalid_d = 1'b1;
          arlen_d   = 8'(next_len - WORDS_W'(1));
        end
      end
      S_DATA: begin
        if (m_axi_rvalid_i && m_axi_rlast_i)
          state_d = (words_left_q == '0) ? S_DRAIN : S_REQ;
      end
      S_DRAIN: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    pix_idx_d = pix_idx_q;
    col_d     = col_q;
    first_d   = first_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    if (accept) begin
      pix_idx_d = beat_done ? '0 : pix_idx_q + PIX_W'(1);
      col_d     = tlast ? '0 : col_q + C_IMG_WBITS'(1);
      first_d   = 1'b0;
    end
    // The previous frame has fully drained before S_START, so restarting the
    // line/frame position here cannot clip a pixel in flight.
    if (state_q == S_START) begin
      pix_idx_d = '0;
      col_d     = '0;
      first_d   = 1'b1;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      width_q      <= '0;
      words_left_q <= '0;
      arvalid_q    <= 1'b0;
      arlen_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pix_idx_q    <= '0;
      col_q        <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      width_q      <= width_d;
      words_left_q <= words_left_d;
      arvalid_q    <= arvalid_d;
      arlen_q      <= arlen_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pix_idx_q    <= pix_idx_d;
      col_q        <= col_d;
      first_q      <= first_d;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (push) mem_q[wr_ptr_q] <= m_axi_rdata_i;
  end

  assign mm2s_sof_o      = (state_q == S_START);
  assign m_axis_tvalid_o = tvalid;
  assign m_axis_tdata_o  = tvalid ? fifo_head[pix_idx_q*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] : '0;
  assign m_axis_tuser_o  = tvalid & first_q;
  assign m_axis_tlast_o  = tlast;

  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = arlen_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_arsize_o  = 3'($clog2(BYTES));
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = 4'b0011;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arqos_o   = 4'b0000;

`ifdef MM2S_RESP_CHK_EN
  logic rresp_err_q, rresp_err_d;
  logic unused_rresp;
  assign unused_rresp = m_axi_rresp_i[0];
  assign rresp_err_d  = rresp_err_q | (push & m_axi_rresp_i[1]);
  always_ff @(posedge aclk_i) begin
    if (reset_i) rresp_err_q <= 1'b0;
    else         rresp_err_q <= rresp_err_d;
  end
  assign mm2s_rresp_err_o = rresp_err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp_i;
`endif

endmodule
